// File: rtl/mem_access_arbiter_if.sv
// Handshake and memory-port bundle for mem_access_arbiter.
// The arbiter uses the slave modport. The requesters and the memory use the master modport.
interface mem_access_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;

    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    logic [9:0]  mem_address;
    logic [31:0] mem_writeData;
    logic        mem_MemWrite;
    logic        mem_readMode;
    logic [4:0]  mem_displayAddress;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_err, cpu_rdata,
        input  dbg_req, dbg_addr,
        output dbg_ack, dbg_rdata,
        output mem_address, mem_writeData, mem_MemWrite, mem_readMode, mem_displayAddress,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_err, cpu_rdata,
        output dbg_req, dbg_addr,
        input  dbg_ack, dbg_rdata,
        input  mem_address, mem_writeData, mem_MemWrite, mem_readMode, mem_displayAddress,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Arbitrates the shared instruction/data memory port between the CPU and the debug/display reader.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a debug grant after STARVE_MAX contended CPU grants.
module mem_access_arbiter #(
    parameter int ADDRESS    = 80,
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [9:0] DATA_BASE = 10'(ADDRESS);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 3 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_param_check
        $error("mem_access_arbiter: RD_LATENCY must be 1..3 and STARVE_MAX 1..7");
    end

    logic [1:0]  state_reg;
    logic        grant_dbg_reg;
    logic        we_reg;
    logic [1:0]  wait_cnt_reg;
    logic        cpu_ack_reg;
    logic        cpu_err_reg;
    logic        dbg_ack_reg;
    logic [31:0] cpu_rdata_reg;
    logic [31:0] dbg_rdata_reg;
    logic [9:0]  mem_address_reg;
    logic [31:0] mem_writeData_reg;
    logic        mem_MemWrite_reg;
    logic        mem_readMode_reg;
    logic [4:0]  mem_displayAddress_reg;

    logic cpu_illegal;
    logic pick_dbg;

    // Misaligned, past the last word, or a write into the read-only instruction region.
    assign cpu_illegal = (bus.cpu_addr[1:0] != 2'b00) ||
                         (bus.cpu_addr > 10'd1020) ||
                         (bus.cpu_we && (bus.cpu_addr < DATA_BASE));

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt_reg;

    assign pick_dbg = bus.dbg_req && (!bus.cpu_req || (starve_cnt_reg == 3'(STARVE_MAX)));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= 3'd0;
        end else if (state_reg == IDLE) begin
            if (!bus.dbg_req || pick_dbg) begin
                starve_cnt_reg <= 3'd0;
            end else if (bus.cpu_req) begin
                starve_cnt_reg <= starve_cnt_reg + 3'd1;
            end
        end
    end
`else
    assign pick_dbg = bus.dbg_req && !bus.cpu_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg              <= IDLE;
            grant_dbg_reg          <= 1'b0;
            we_reg                 <= 1'b0;
            wait_cnt_reg           <= 2'd0;
            cpu_ack_reg            <= 1'b0;
            cpu_err_reg            <= 1'b0;
            dbg_ack_reg            <= 1'b0;
            cpu_rdata_reg          <= 32'd0;
            dbg_rdata_reg          <= 32'd0;
            mem_address_reg        <= 10'd0;
            mem_writeData_reg      <= 32'd0;
            mem_MemWrite_reg       <= 1'b0;
            mem_readMode_reg       <= 1'b0;
            mem_displayAddress_reg <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_dbg) begin
                        grant_dbg_reg          <= 1'b1;
                        we_reg                 <= 1'b0;
                        // Pointing at the data region keeps that memory bank enabled for the display path.
                        mem_address_reg        <= DATA_BASE;
                        mem_displayAddress_reg <= bus.dbg_addr;
                        mem_readMode_reg       <= 1'b1;
                        mem_MemWrite_reg       <= 1'b0;
                        state_reg              <= ISSUE;
                    end else if (bus.cpu_req) begin
                        grant_dbg_reg <= 1'b0;
                        we_reg        <= bus.cpu_we;
                        if (cpu_illegal) begin
                            cpu_ack_reg <= 1'b1;
                            cpu_err_reg <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            mem_address_reg   <= bus.cpu_addr;
                            mem_writeData_reg <= bus.cpu_wdata;
                            mem_MemWrite_reg  <= bus.cpu_we;
                            mem_readMode_reg  <= 1'b0;
                            state_reg         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (we_reg) begin
                        mem_MemWrite_reg <= 1'b0;
                        cpu_ack_reg      <= 1'b1;
                        cpu_err_reg      <= 1'b0;
                        state_reg        <= DONE;
                    end else begin
                        wait_cnt_reg <= WAIT_LAST;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == 2'd0) begin
                        mem_readMode_reg <= 1'b0;
                        if (grant_dbg_reg) begin
                            dbg_rdata_reg <= bus.mem_rdata;
                            dbg_ack_reg   <= 1'b1;
                        end else begin
                            cpu_rdata_reg <= bus.mem_rdata;
                            cpu_ack_reg   <= 1'b1;
                            cpu_err_reg   <= 1'b0;
                        end
                        state_reg <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end
                end
                default: begin
                    cpu_ack_reg <= 1'b0;
                    cpu_err_reg <= 1'b0;
                    dbg_ack_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack            = cpu_ack_reg;
    assign bus.cpu_err            = cpu_err_reg;
    assign bus.cpu_rdata          = cpu_rdata_reg;
    assign bus.dbg_ack            = dbg_ack_reg;
    assign bus.dbg_rdata          = dbg_rdata_reg;
    assign bus.mem_address        = mem_address_reg;
    assign bus.mem_writeData      = mem_writeData_reg;
    assign bus.mem_MemWrite       = mem_MemWrite_reg;
    assign bus.mem_readMode       = mem_readMode_reg;
    assign bus.mem_displayAddress = mem_displayAddress_reg;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a one-cycle-latency memory model behind it.
// The contention expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_access_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_access_arbiter_if bus ();

    mem_access_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: byte-addressed writes and a registered read. The display path indexes words from the data base.
    logic [31:0] ram [0:255];
    logic [7:0]  rd_idx;
    assign rd_idx = bus.mem_readMode ? (8'd20 + 8'(bus.mem_displayAddress)) : bus.mem_address[9:2];

    always @(posedge clk) begin
        if (bus.mem_MemWrite) ram[bus.mem_address[9:2]] <= bus.mem_writeData;
        bus.mem_rdata <= ram[rd_idx];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Starts at a negedge with the arbiter idle; ends at the negedge of the idle cycle after the ack.
    task automatic cpu_xfer(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                            output int ack_cyc, output int we_pulses, output logic err);
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_req   = 1'b1;
        ack_cyc   = -1;
        we_pulses = 0;
        err       = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.mem_MemWrite) we_pulses++;
            if (bus.cpu_ack) begin
                ack_cyc = k;
                err     = bus.cpu_err;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        $display("cpu  we=%0d addr=%0d wdata=0x%08h ack_cycle=%0d err=%0d rdata=0x%08h",
                 we, addr, wdata, ack_cyc, err, bus.cpu_rdata);
        @(negedge clk);
    endtask

    task automatic dbg_xfer(input logic [4:0] idx, output int ack_cyc, output int disp_cycles);
        bus.dbg_addr = idx;
        bus.dbg_req  = 1'b1;
        ack_cyc     = -1;
        disp_cycles = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.mem_readMode && bus.mem_address == 10'd80 && bus.mem_displayAddress == idx) disp_cycles++;
            if (bus.dbg_ack) begin
                ack_cyc = k;
                break;
            end
        end
        bus.dbg_req = 1'b0;
        $display("dbg  idx=%0d ack_cycle=%0d rdata=0x%08h", idx, ack_cyc, bus.dbg_rdata);
        @(negedge clk);
    endtask

    int   ack_cyc, we_pulses, disp_cycles, cpu_acks, dbg_acks, late_acks;
    logic err;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE0000 | 32'(i);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 10'd0; bus.cpu_wdata = 32'd0;
        bus.dbg_req = 1'b0; bus.dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ack",    32'(bus.cpu_ack),      32'd0);
        check("rst_dbg_ack",    32'(bus.dbg_ack),      32'd0);
        check("rst_memwrite",   32'(bus.mem_MemWrite), 32'd0);
        check("rst_readmode",   32'(bus.mem_readMode), 32'd0);
        check("rst_mem_addr",   32'(bus.mem_address),  32'd0);
        check("rst_cpu_rdata",  bus.cpu_rdata,         32'd0);
        rst = 1'b0;
        @(negedge clk);

        cpu_xfer(1'b1, 10'd84, 32'hDEADBEEF, ack_cyc, we_pulses, err);
        check("wr84_ack_cycle", 32'(ack_cyc),   32'd2);
        check("wr84_we_pulses", 32'(we_pulses), 32'd1);
        check("wr84_err",       32'(err),       32'd0);

        cpu_xfer(1'b0, 10'd84, 32'd0, ack_cyc, we_pulses, err);
        check("rd84_ack_cycle", 32'(ack_cyc),   32'd3);
        check("rd84_rdata",     bus.cpu_rdata,  32'hDEADBEEF);
        check("rd84_err",       32'(err),       32'd0);

        cpu_xfer(1'b1, 10'd8, 32'h0BADF00D, ack_cyc, we_pulses, err);
        check("wr8_ack_cycle",  32'(ack_cyc),   32'd1);
        check("wr8_err",        32'(err),       32'd1);
        check("wr8_we_pulses",  32'(we_pulses), 32'd0);
        check("wr8_ram_intact", ram[2],         32'hC0DE0002);

        cpu_xfer(1'b0, 10'd86, 32'd0, ack_cyc, we_pulses, err);
        check("rd86_ack_cycle", 32'(ack_cyc),   32'd1);
        check("rd86_err",       32'(err),       32'd1);

        cpu_xfer(1'b0, 10'd1020, 32'd0, ack_cyc, we_pulses, err);
        check("rd1020_ack_cycle", 32'(ack_cyc), 32'd3);
        check("rd1020_err",     32'(err),       32'd0);
        check("rd1020_rdata",   bus.cpu_rdata,  32'hC0DE00FF);

        cpu_xfer(1'b1, 10'd84, 32'h12345678, ack_cyc, we_pulses, err);
        check("wr84b_ack_cycle", 32'(ack_cyc),  32'd2);
        dbg_xfer(5'd1, ack_cyc, disp_cycles);
        check("dbg_ack_cycle",  32'(ack_cyc),     32'd3);
        check("dbg_disp_cycles", 32'(disp_cycles), 32'd2);
        check("dbg_rdata",      bus.dbg_rdata,    32'h12345678);
        check("dbg_readmode_off", 32'(bus.mem_readMode), 32'd0);
        check("cpu_rdata_held", bus.cpu_rdata,    32'hC0DE00FF);

        // Contention: both requesters held high, CPU reading word 84.
        bus.cpu_we = 1'b0; bus.cpu_addr = 10'd84; bus.cpu_req = 1'b1;
        bus.dbg_addr = 5'd1; bus.dbg_req = 1'b1;
        cpu_acks = 0; dbg_acks = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.cpu_ack) cpu_acks++;
            if (bus.dbg_ack) begin
                dbg_acks++;
                break;
            end
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
        $display("contention cpu_acks=%0d dbg_acks=%0d", cpu_acks, dbg_acks);
        @(negedge clk);
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("contend_cpu_acks", 32'(cpu_acks), 32'd4);
        check("contend_dbg_acks", 32'(dbg_acks), 32'd1);
`else
        check("contend_cpu_acks", 32'(cpu_acks), 32'd10);
        check("contend_dbg_acks", 32'(dbg_acks), 32'd0);
`endif

        // Reset while the read is in WAIT (cycle 2).
        bus.cpu_we = 1'b0; bus.cpu_addr = 10'd84; bus.cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state",    32'(dut.state_reg),    32'd0);
        check("mid_rst_cpu_ack",  32'(bus.cpu_ack),      32'd0);
        check("mid_rst_memwrite", 32'(bus.mem_MemWrite), 32'd0);
        check("mid_rst_readmode", 32'(bus.mem_readMode), 32'd0);
        check("mid_rst_rdata",    bus.cpu_rdata,         32'd0);
        late_acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.dbg_ack) late_acks++;
        end
        $display("reset mid-read late_acks=%0d", late_acks);
        check("mid_rst_no_ack",   32'(late_acks),        32'd0);

        cpu_xfer(1'b0, 10'd84, 32'd0, ack_cyc, we_pulses, err);
        check("post_rst_ack_cycle", 32'(ack_cyc),  32'd3);
        check("post_rst_rdata",   bus.cpu_rdata,   32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequencer and arbiter in front of the unified instruction/data memory of the multicycle core. It shares the single memory port between the CPU port and the debug/display port. It handles the block-RAM read latency, pulses write-enable for exactly one cycle, and rejects illegal accesses. Each requester gets a req/ack handshake, so neither needs to know the memory's timing.

## Interface
Parameters:
- ADDRESS, 80: byte boundary of the instruction region. Addresses below it are instruction memory (read-only); addresses at or above it are data memory.
- RD_LATENCY, 1: memory read latency in cycles, range 1–3.
- STARVE_MAX, 4: maximum consecutive CPU grants while a debug request is pending.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- cpu_req, input, 1: CPU access request; held high until cpu_ack.
- cpu_we, input, 1: 1 = write, 0 = read.
- cpu_addr, input, 10: byte address.
- cpu_wdata, input, 32: write data.
- cpu_ack, output, 1: one-cycle completion pulse.
- cpu_err, output, 1: valid with cpu_ack; access was rejected.
- cpu_rdata, output, 32: read data, valid with cpu_ack and held until the next CPU ack.
- dbg_req, input, 1: debug word-read request; held high until dbg_ack.
- dbg_addr, input, 5: data-memory word index.
- dbg_ack, output, 1: one-cycle completion pulse.
- dbg_rdata, output, 32: read data, valid with dbg_ack and held until the next debug ack.
- mem_address, output, 10: memory byte address.
- mem_writeData, output, 32: memory write data.
- mem_MemWrite, output, 1: memory write enable.
- mem_readMode, output, 1: selects the display-address path in the memory.
- mem_displayAddress, output, 5: word index for the display path.
- mem_rdata, input, 32: memory read word.

## Operation
States: IDLE, ISSUE, WAIT, DONE.

IDLE: arbitration.
- CPU has priority by default.
- A pending request is registered as the grant; the next state is ISSUE.

Legality check (CPU grants, evaluated in IDLE):
- An access is illegal if cpu_addr[1:0] != 0, or cpu_addr > 1020, or (cpu_we && cpu_addr < ADDRESS).
- Illegal access: go directly to DONE with cpu_err=1. No memory write occurs.

ISSUE:
- CPU access: mem_address=cpu_addr, mem_writeData=cpu_wdata, mem_MemWrite=cpu_we, mem_readMode=0.
- Debug access: mem_readMode=1, mem_displayAddress=dbg_addr, mem_address=ADDRESS (keeps the data memory enabled), mem_MemWrite=0.
- Write: next state is DONE. Read: next state is WAIT.

WAIT:
- Holds all mem_* outputs for RD_LATENCY cycles.
- On the final cycle, mem_rdata is registered into the granted port's rdata.
- Next state is DONE.

DONE:
- Granted port's ack=1 for this single cycle.
- mem_MemWrite=0, mem_readMode=0.
- Next state is IDLE.

Outside ISSUE and WAIT:
- mem_MemWrite=0 and mem_readMode=0.
- mem_address and mem_writeData hold their last values.

Grant rules:
- Only one grant is in flight at a time. A request arriving mid-transaction waits in IDLE.
- Simultaneous cpu_req and dbg_req in IDLE: CPU wins, unless the starvation guard forces debug (see Configuration).
- A req dropped before its ack is a protocol violation. The transaction still completes and the ack still pulses.

Reset:
- rst in any state: next state is IDLE; all acks, cpu_err, mem_MemWrite and mem_readMode go to 0; the starvation counter goes to 0.
- The in-flight transaction is abandoned with no ack.
- cpu_rdata, dbg_rdata, mem_address and mem_writeData reset to 0.

## Timing
Let cycle 0 be the cycle in which a request is sampled in IDLE.
- Write: ISSUE in cycle 1 (mem_MemWrite high for exactly that cycle); ack in cycle 2.
- Read: ISSUE in cycle 1; WAIT in cycles 2 to 1+RD_LATENCY; ack in cycle 2+RD_LATENCY. With the default RD_LATENCY, ack is in cycle 3.
- Rejected CPU access: ack with cpu_err in cycle 1.
- Back-to-back: the next grant can be sampled in the cycle after DONE.
  - Requester behaviour: it deasserts req in the cycle after seeing ack.
  - Throughput: one read per 4 cycles at the default latency.
- All outputs are registered; there is no combinational path from any req to any ack.

## Configuration
MEM_ARB_STARVE_GUARD_EN, defined:
- A 3-bit counter increments on each CPU grant issued while dbg_req is high.
- When the counter equals STARVE_MAX and dbg_req is high in IDLE, debug is granted even if cpu_req is high.
- The counter clears on any debug grant, and whenever dbg_req is low in IDLE.

MEM_ARB_STARVE_GUARD_EN, undefined:
- Strict CPU priority. Debug is granted only when cpu_req is low in IDLE.
- No counter is instantiated.

## Test plan
- CPU write, then read: cpu_addr=84 with cpu_wdata=0xDEADBEEF writes, then a read of cpu_addr=84 returns it.
  - Write: mem_MemWrite high for exactly 1 cycle, cpu_ack in cycle 2, cpu_err=0.
  - Read: cpu_ack in cycle 3, cpu_rdata=0xDEADBEEF.
- Illegal CPU accesses:
  - Write to cpu_addr=8: cpu_ack and cpu_err=1 in cycle 1; mem_MemWrite never asserts.
  - Read of cpu_addr=86: cpu_err=1.
  - Read of cpu_addr=1024-4=1020: legal, cpu_err=0.
- Debug read: dbg_addr=1 after the CPU has written 0x12345678 to cpu_addr=ADDRESS+4.
  - Required: mem_readMode=1 and mem_address=80 during ISSUE/WAIT; dbg_ack in cycle 3; dbg_rdata=0x12345678.
- Contention: cpu_req held continuously (acks acknowledged) while dbg_req is held high.
  - With MEM_ARB_STARVE_GUARD_EN: debug is granted after exactly 4 CPU grants.
  - Without it: no dbg_ack while cpu_req stays high.
- Reset mid-read: rst asserted during WAIT.
  - Required: no ack is produced; mem_MemWrite=0 and mem_readMode=0 the next cycle; the state is IDLE.
  - A new CPU read then completes with normal latency.
